dmem_sized: RTL
===============

Name: dmem_sized

Overview:
- Parametrised successor to the single-cycle word data memory. Adds byte, half and word loads/stores, sign/zero extension, byte-lane write enables and a valid/ready request channel.
- Adds configurable wait states and a registered response with error reporting.
- Sits on the MEM stage of the RV32 core; the stage stalls on req_ready/rsp_valid.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two.
- ADDR_W, 32, width of req_addr in bytes.
- WAIT_STATES, 0, extra cycles between accept and response (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  mem_size_t: 00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: zero-extend when 1 (LBU/LHU), sign-extend when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle pulse; response present.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access faulted; valid only with rsp_valid.

Behaviour:
- Handshake
  - Accept occurs on a rising edge with req_valid && req_ready.
  - req_ready = (state == IDLE) || (state == RESP).
  - Request inputs are sampled only on accept.
- FSM states: IDLE, WAIT, RESP.
  - Accept from IDLE or RESP goes to RESP if WAIT_STATES == 0, else to WAIT with cnt = WAIT_STATES-1.
  - WAIT: decrement cnt; when cnt == 0, go to RESP.
  - RESP: rsp_valid = 1 for exactly one cycle; then go to IDLE, or stay in RESP/WAIT on a back-to-back accept.
- Latency: response appears WAIT_STATES+1 cycles after accept. With WAIT_STATES=0, sustains one access per cycle.
- Addressing
  - Word index = req_addr[log2(DEPTH)+1:2]; lane = req_addr[1:0].
  - Address out of range (any bit above log2(DEPTH)+1 set): err, no write, rdata 0.
- Store
  - Memory write commits on the accept edge.
  - byte: lane be = 1<<addr[1:0]; data replicated x4.
  - half: be = 0011 or 1100 by addr[1]; data replicated x2.
  - word: be = 1111.
  - Unwritten lanes are unchanged.
- Load
  - Word read on the accept edge into a holding register; extraction/extension applied from the registered lane/size/unsigned fields.
  - A store accepted in the same edge as an earlier load does not disturb that load's held data.
- Misalignment (half with addr[0]=1, word with addr[1:0]!=0) and req_size=11: behaviour per Optional Feature.
- Reset: async assert forces state IDLE, cnt 0, rsp_valid 0, rsp_rdata 0, rsp_err 0.
  - req_ready is 1 after reset (IDLE).
  - An in-flight response is dropped; memory contents are not reset.
  - A store already accepted stays committed.
- Memory array has no reset and no initial value requirement.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined: misaligned or size=11 accesses return rsp_err=1 and rsp_rdata=0; stores do not write.
- Undefined: offending low address bits are forced to 0 (natural alignment); size=11 is treated as word; rsp_err is driven only by out-of-range addresses.

Decomposition:
- Package dmem_pkg
  - typedef enum logic [1:0] mem_size_t {MEM_B, MEM_H, MEM_W, MEM_X}.
  - typedef enum dmem_state_t {IDLE, WAIT, RESP}.
  - localparam MAX_WAIT = 15.
  - Function funct3_to_size for decode.
- Sub-module dmem_lane_align (combinational)
  - Store side: size, addr[1:0], wdata -> be[3:0], wdata_rep, misaligned.
  - Load side: raw word, size, addr[1:0], unsigned -> extended rdata.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 (WAIT_STATES=0) -> rsp_valid 1 cycle after each accept; rdata 0xDEADBEEF.
- SB 0x7F @0x11 over 0xDEADBEEF, LW @0x10 -> 0xDEAD7FEF. LB @0x13 -> 0xFFFFFFDE. LBU @0x13 -> 0x000000DE.
- SH 0x8001 @0x22, then LH @0x22 -> 0xFFFF8001; LHU -> 0x00008001. Word @0x20 keeps its low half.
- WAIT_STATES=3, LW accept at cycle 0 -> req_ready 0 for cycles 1-3, rsp_valid at cycle 4; back-to-back accept in the RESP cycle works.
- With DMEM_MISALIGN_TRAP_EN: SW @0x12 -> rsp_err 1, word @0x10 unchanged. Without it: SW @0x12 writes word @0x10, rsp_err 0. Address 4*DEPTH -> rsp_err 1 in both builds.
- rst_n low during WAIT -> rsp_valid never pulses; req_ready 1 after release; next LW returns correct data.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the sized data memory.
//   mem_size_t    - access size encoding (byte/half/word/illegal)
//   dmem_state_t  - response sequencer states
//   MAX_WAIT      - largest supported WAIT_STATES value
//   funct3_to_size/funct3_is_unsigned - decode of RV32 load/store funct3
package dmem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10,
    MEM_X = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_t;

  localparam int MAX_WAIT = 15;

  // funct3[1:0] carries the size; funct3[2] selects zero-extension on loads.
  function automatic mem_size_t funct3_to_size(input logic [2:0] funct3);
    mem_size_t size_v;
    case (funct3[1:0])
      2'b00:   size_v = MEM_B;
      2'b01:   size_v = MEM_H;
      2'b10:   size_v = MEM_W;
      default: size_v = MEM_X;
    endcase
    return size_v;
  endfunction

  function automatic logic funct3_is_unsigned(input logic [2:0] funct3);
    return funct3[2];
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for dmem_sized.
// Store side:
//   st_size, st_lane, st_wdata -> st_be (byte enables), st_wdata_rep
//   (data replicated onto every lane), st_misaligned, and the naturally
//   aligned size/lane (aln_size, aln_lane) used when misalignment is not trapped.
// Load side:
//   ld_word (raw memory word), ld_size, ld_lane, ld_unsigned -> ld_rdata
//   (selected lane, sign- or zero-extended to 32 bits).
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  output logic        st_misaligned,
  output logic [1:0]  aln_size,
  output logic [1:0]  aln_lane,
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lane,
  input  logic        ld_unsigned,
  output logic [31:0] ld_rdata
);

  logic [31:0] shifted_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Classify the store/load request and normalise size 11 and low lane bits.
  always_comb begin
    st_misaligned = 1'b0;
    aln_size      = 2'(MEM_W);
    aln_lane      = 2'b00;
    case (mem_size_t'(st_size))
      MEM_B: begin
        st_misaligned = 1'b0;
        aln_size      = 2'(MEM_B);
        aln_lane      = st_lane;
      end
      MEM_H: begin
        st_misaligned = st_lane[0];
        aln_size      = 2'(MEM_H);
        aln_lane      = {st_lane[1], 1'b0};
      end
      MEM_W: begin
        st_misaligned = (st_lane != 2'b00);
        aln_size      = 2'(MEM_W);
        aln_lane      = 2'b00;
      end
      default: begin
        // Illegal size is always flagged; when not trapped it acts as a word.
        st_misaligned = 1'b1;
        aln_size      = 2'(MEM_W);
        aln_lane      = 2'b00;
      end
    endcase
  end

  // Byte enables and lane-replicated write data from the aligned size/lane.
  always_comb begin
    st_be        = 4'b1111;
    st_wdata_rep = st_wdata;
    case (mem_size_t'(aln_size))
      MEM_B: begin
        st_be        = 4'b0001 << aln_lane;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      MEM_H: begin
        if (aln_lane[1]) begin
          st_be = 4'b1100;
        end else begin
          st_be = 4'b0011;
        end
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      default: begin
        st_be        = 4'b1111;
        st_wdata_rep = st_wdata;
      end
    endcase
  end

  assign shifted_s = ld_word >> {ld_lane, 3'b000};
  assign byte_s    = shifted_s[7:0];
  assign half_s    = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];

  // Load extraction with sign or zero extension.
  always_comb begin
    ld_rdata = ld_word;
    case (mem_size_t'(ld_size))
      MEM_B: begin
        if (ld_unsigned) begin
          ld_rdata = {24'h000000, byte_s};
        end else begin
          ld_rdata = {{24{byte_s[7]}}, byte_s};
        end
      end
      MEM_H: begin
        if (ld_unsigned) begin
          ld_rdata = {16'h0000, half_s};
        end else begin
          ld_rdata = {{16{half_s[15]}}, half_s};
        end
      end
      default: begin
        ld_rdata = ld_word;
      end
    endcase
  end

endmodule

// File: rtl/dmem_sized.sv
// dmem_sized: byte/half/word data memory with a valid/ready request channel,
// configurable wait states and a one-cycle response pulse with error flag.
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   req_valid/ready - request handshake; accept on req_valid && req_ready
//   req_we          - 1 store, 0 load
//   req_size        - 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned    - zero-extend loads when 1
//   req_addr        - byte address (ADDR_W bits)
//   req_wdata       - right-justified store data
//   rsp_valid       - one-cycle response pulse, WAIT_STATES+1 cycles after accept
//   rsp_rdata       - extended load data; 0 for stores and faulted accesses
//   rsp_err         - out-of-range (or trapped misaligned/illegal) access
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned and size-11
// accesses; otherwise they are naturally aligned and size 11 acts as a word.
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);
  localparam logic       HAS_WAIT  = (WAIT_STATES != 0);

  logic [31:0] mem_r [DEPTH];

  dmem_state_t state_r;
  dmem_state_t state_nxt_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_nxt_s;

  logic [31:0] hold_word_r;
  logic [1:0]  hold_size_r;
  logic [1:0]  hold_lane_r;
  logic        hold_uns_r;
  logic        hold_we_r;
  logic        hold_err_r;
  logic        rsp_valid_r;

  logic [IDX_W-1:0] word_idx_s;
  logic             oor_s;
  logic             err_s;
  logic             accept_s;
  logic             wr_en_s;
  logic [3:0]       be_s;
  logic [31:0]      wdata_rep_s;
  logic             misaligned_s;
  logic [1:0]       aln_size_s;
  logic [1:0]       aln_lane_s;
  logic [31:0]      ld_rdata_s;

  assign word_idx_s = req_addr[IDX_W+1:2];
  // Any address bit above the word index means the access is outside the array.
  assign oor_s      = |(req_addr >> (IDX_W + 2));

`ifdef DMEM_MISALIGN_TRAP_EN
  assign err_s = oor_s | misaligned_s;
`else
  assign err_s = oor_s;
`endif

  assign req_ready = (state_r == IDLE) || (state_r == RESP);
  assign accept_s  = req_valid && req_ready;
  assign wr_en_s   = accept_s && req_we && !err_s;

  dmem_lane_align u_lane_align (
    .st_size       (req_size),
    .st_lane       (req_addr[1:0]),
    .st_wdata      (req_wdata),
    .st_be         (be_s),
    .st_wdata_rep  (wdata_rep_s),
    .st_misaligned (misaligned_s),
    .aln_size      (aln_size_s),
    .aln_lane      (aln_lane_s),
    .ld_word       (hold_word_r),
    .ld_size       (hold_size_r),
    .ld_lane       (hold_lane_r),
    .ld_unsigned   (hold_uns_r),
    .ld_rdata      (ld_rdata_s)
  );

  // Memory array: byte-lane write committed on the accept edge, never reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          mem_r[word_idx_s][8*b +: 8] <= wdata_rep_s[8*b +: 8];
        end
      end
    end
  end

  // Next-state and wait-counter logic of the response sequencer.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE, RESP: begin
        if (accept_s) begin
          if (HAS_WAIT) begin
            state_nxt_s = WAIT;
            cnt_nxt_s   = WAIT_LOAD;
          end else begin
            state_nxt_s = RESP;
            cnt_nxt_s   = 4'd0;
          end
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = RESP;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State, counter and response-valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      rsp_valid_r <= (state_nxt_s == RESP);
    end
  end

  // Request capture: raw word plus the aligned fields needed to extract it later.
  // Only an accept updates these, so a back-to-back store cannot disturb a load
  // whose response is already being presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_word_r <= 32'h0000_0000;
      hold_size_r <= 2'b00;
      hold_lane_r <= 2'b00;
      hold_uns_r  <= 1'b0;
      hold_we_r   <= 1'b0;
      hold_err_r  <= 1'b0;
    end else if (accept_s) begin
      hold_word_r <= mem_r[word_idx_s];
      hold_size_r <= aln_size_s;
      hold_lane_r <= aln_lane_s;
      hold_uns_r  <= req_unsigned;
      hold_we_r   <= req_we;
      hold_err_r  <= err_s;
    end else begin
      hold_word_r <= hold_word_r;
      hold_size_r <= hold_size_r;
      hold_lane_r <= hold_lane_r;
      hold_uns_r  <= hold_uns_r;
      hold_we_r   <= hold_we_r;
      hold_err_r  <= hold_err_r;
    end
  end

  // Response outputs: data only for successful loads, all zero outside the pulse.
  always_comb begin
    rsp_valid = rsp_valid_r;
    rsp_rdata = 32'h0000_0000;
    rsp_err   = 1'b0;
    if (rsp_valid_r) begin
      rsp_err = hold_err_r;
      if (!hold_we_r && !hold_err_r) begin
        rsp_rdata = ld_rdata_s;
      end else begin
        rsp_rdata = 32'h0000_0000;
      end
    end else begin
      rsp_err   = 1'b0;
      rsp_rdata = 32'h0000_0000;
    end
  end

endmodule
